match_dispatch: RTL and testbench

- Consumer end of the tagged packet stream that the packet-memory group emits, one stream per interface (4 interfaces).
- Classifies each packet by its destination MAC using a programmable table.
- Returns one match result per packet on the 10-bit tag interface that the packet-memory group consumes.
- Queues results per input interface, then merges them round-robin onto the single result port with valid/ready backpressure.

---
 rtl/match_dispatch.sv | 273 +++++++++++++++++++++++++++
 tb/tb_match_dispatch.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_dispatch.sv
// match_dispatch
//   Consumes the four tagged packet streams from the packet-memory group,
//   classifies each packet by destination MAC against a programmable table,
//   queues one 8-bit {out_port, tag} result per packet in a per-input FIFO
//   and merges the four FIFOs round-robin onto a single 10-bit result port.
//
// Ports
//   clock, reset             single clock, asynchronous active-low reset
//   packetout_data/valid/sop/eop/channel/ready
//                            four input beat streams (MAC in [63:16] of SOP)
//   tagin_data/valid/ready   result stream {out_port, in_iface, tag}
//   cfg_wr/idx/mac/port/en   MAC table write port
//   drop_count               saturating count of malformed-packet drops
//   stat_issued              per-output-port issue counters (MATCH_STATS_EN)
//
// Build option
//   MATCH_STATS_EN  adds stat_issued, one 32-bit wrapping counter per output
//                   interface, bumped on every result handshake.

module match_dispatch #(
  parameter int         NUM_ENTRIES  = 16,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [1:0] DEFAULT_PORT = 2'd0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [3:0][63:0]               packetout_data,
  input  logic [3:0]                     packetout_valid,
  input  logic [3:0]                     packetout_sop,
  input  logic [3:0]                     packetout_eop,
  input  logic [3:0][5:0]                packetout_channel,
  output logic [3:0]                     packetout_ready,
  output logic [9:0]                     tagin_data,
  output logic                           tagin_valid,
  input  logic                           tagin_ready,
  input  logic                           cfg_wr,
  input  logic [$clog2(NUM_ENTRIES)-1:0] cfg_idx,
  input  logic [47:0]                    cfg_mac,
  input  logic [1:0]                     cfg_port,
  input  logic                           cfg_en,
  output logic [15:0]                    drop_count
`ifdef MATCH_STATS_EN
  ,
  output logic [3:0][31:0]               stat_issued
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, INPKT} pkt_state_t;

  // MAC table
  logic [NUM_ENTRIES-1:0] ent_valid;
  logic [47:0]            ent_mac  [NUM_ENTRIES];
  logic [1:0]             ent_port [NUM_ENTRIES];

  // Per-input packet tracking
  pkt_state_t state     [4];
  pkt_state_t state_nxt [4];
  logic [1:0] cap_port  [4];
  logic [5:0] cap_tag   [4];
  logic [1:0] lk_port   [4];
  logic [3:0] beat;
  logic [3:0] capture;
  logic [3:0] drop;
  logic [3:0] push;
  logic [7:0] push_data [4];

  // Result FIFOs
  logic [7:0]  fifo_mem [4][FIFO_DEPTH];
  logic [AW:0] wr_ptr   [4];
  logic [AW:0] rd_ptr   [4];
  logic [3:0]  fifo_full;
  logic [3:0]  fifo_empty;
  logic [7:0]  head     [4];
  logic [3:0]  pop;

  // Arbiter
  logic [1:0] rr_ptr;
  logic [1:0] grant;
  logic [1:0] cand;
  logic       grant_found;
  logic       load;

  logic [2:0]  drop_sum;
  logic [16:0] drop_next;
  logic        unused_low_bits;

  assign beat            = packetout_valid & packetout_ready;
  assign packetout_ready = ~fifo_full;
  assign load            = !tagin_valid || tagin_ready;

  // Only the MAC field of the data bus is inspected.
  always_comb begin
    unused_low_bits = 1'b0;
    for (int i = 0; i < 4; i++) unused_low_bits = unused_low_bits ^ (^packetout_data[i][15:0]);
  end

  // Table writes land at the clock edge, so a lookup in the same cycle
  // still sees the old entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ent_valid <= '0;
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        ent_mac[e]  <= '0;
        ent_port[e] <= '0;
      end
    end else if (cfg_wr) begin
      ent_valid[cfg_idx] <= cfg_en;
      ent_mac[cfg_idx]   <= cfg_mac;
      ent_port[cfg_idx]  <= cfg_port;
    end
  end

  // Scanning from the top down lets the lowest matching index win.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lk_port[i] = DEFAULT_PORT;
      for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
        if (ent_valid[e] && (ent_mac[e] == packetout_data[i][63:16])) lk_port[i] = ent_port[e];
      end
    end
  end

  // Per-input packet state machine. An SOP always restarts capture; an SOP
  // arriving mid-packet abandons the earlier packet and counts as a drop.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_nxt[i] = state[i];
      capture[i]   = 1'b0;
      drop[i]      = 1'b0;
      push[i]      = 1'b0;
      push_data[i] = {lk_port[i], packetout_channel[i]};
      if (beat[i]) begin
        case (state[i])
          IDLE: begin
            if (packetout_sop[i]) begin
              if (packetout_eop[i]) begin
                push[i] = 1'b1;
              end else begin
                capture[i]   = 1'b1;
                state_nxt[i] = INPKT;
              end
            end else if (packetout_eop[i]) begin
              drop[i] = 1'b1;
            end
          end
          INPKT: begin
            if (packetout_sop[i]) begin
              drop[i] = 1'b1;
              if (packetout_eop[i]) begin
                push[i]      = 1'b1;
                state_nxt[i] = IDLE;
              end else begin
                capture[i] = 1'b1;
              end
            end else if (packetout_eop[i]) begin
              push[i]      = 1'b1;
              push_data[i] = {cap_port[i], cap_tag[i]};
              state_nxt[i] = IDLE;
            end
          end
          default: state_nxt[i] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        state[i]    <= IDLE;
        cap_port[i] <= '0;
        cap_tag[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= state_nxt[i];
        if (capture[i]) begin
          cap_port[i] <= lk_port[i];
          cap_tag[i]  <= packetout_channel[i];
        end
      end
    end
  end

  // Several inputs can drop in one cycle, so the increments are summed
  // before saturating.
  always_comb begin
    drop_sum  = 3'(drop[0]) + 3'(drop[1]) + 3'(drop[2]) + 3'(drop[3]);
    drop_next = {1'b0, drop_count} + 17'(drop_sum);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) drop_count <= '0;
    else if (drop_next[16]) drop_count <= 16'hFFFF;
    else drop_count <= drop_next[15:0];
  end

  // FIFO status uses one extra pointer bit to tell full from empty.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      fifo_full[i]  = (wr_ptr[i] - rd_ptr[i]) == DEPTH_L;
      fifo_empty[i] = (wr_ptr[i] == rd_ptr[i]);
      head[i]       = fifo_mem[i][rd_ptr[i][AW-1:0]];
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) fifo_mem[i][wr_ptr[i][AW-1:0]] <= push_data[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
    end
  end

  // Round-robin search: first non-empty FIFO at or after the pointer.
  always_comb begin
    grant_found = 1'b0;
    grant       = rr_ptr;
    cand        = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr + 2'(k);
      if (!grant_found && !fifo_empty[cand]) begin
        grant_found = 1'b1;
        grant       = cand;
      end
    end
    for (int i = 0; i < 4; i++) pop[i] = load && grant_found && (grant == 2'(i));
  end

  // The output register only reloads when empty or being accepted, which
  // keeps data stable under backpressure.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tagin_valid <= 1'b0;
      tagin_data  <= '0;
      rr_ptr      <= '0;
    end else if (load) begin
      if (grant_found) begin
        tagin_valid <= 1'b1;
        tagin_data  <= {head[grant][7:6], grant, head[grant][5:0]};
        rr_ptr      <= grant + 2'd1;
      end else begin
        tagin_valid <= 1'b0;
      end
    end
  end

`ifdef MATCH_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_issued <= '0;
    end else if (tagin_valid && tagin_ready) begin
      stat_issued[tagin_data[9:8]] <= stat_issued[tagin_data[9:8]] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_match_dispatch.sv
// tb_match_dispatch
//   Scoreboard bench for match_dispatch: expected results are queued when
//   packets are driven and compared in order as results are handshaken.
//   Build with MATCH_STATS_EN to also exercise stat_issued.

module tb_match_dispatch;

  localparam logic [47:0] MAC_A    = 48'h0011_2233_4455;
  localparam logic [47:0] MAC_MISS = 48'hDEAD_BEEF_0001;
  localparam logic [47:0] MAC_B    = 48'hAABB_CCDD_EEFF;
  localparam logic [47:0] MAC_X    = 48'h0102_0304_0506;

  logic             clock = 1'b0;
  logic             reset;
  logic [3:0][63:0] packetout_data;
  logic [3:0]       packetout_valid;
  logic [3:0]       packetout_sop;
  logic [3:0]       packetout_eop;
  logic [3:0][5:0]  packetout_channel;
  logic [3:0]       packetout_ready;
  logic [9:0]       tagin_data;
  logic             tagin_valid;
  logic             tagin_ready;
  logic             cfg_wr;
  logic [3:0]       cfg_idx;
  logic [47:0]      cfg_mac;
  logic [1:0]       cfg_port;
  logic             cfg_en;
  logic [15:0]      drop_count;
`ifdef MATCH_STATS_EN
  logic [3:0][31:0] stat_issued;
`endif

  int         checks = 0;
  int         errors = 0;
  bit         drive_ok;
  logic [9:0] sb [$];
  logic [9:0] exp_data;
  bit         got;
  int         waited;

  match_dispatch #(.NUM_ENTRIES(16), .FIFO_DEPTH(4), .DEFAULT_PORT(2'd0)) dut (
    .clock(clock), .reset(reset),
    .packetout_data(packetout_data), .packetout_valid(packetout_valid),
    .packetout_sop(packetout_sop), .packetout_eop(packetout_eop),
    .packetout_channel(packetout_channel), .packetout_ready(packetout_ready),
    .tagin_data(tagin_data), .tagin_valid(tagin_valid), .tagin_ready(tagin_ready),
    .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_mac(cfg_mac), .cfg_port(cfg_port),
    .cfg_en(cfg_en), .drop_count(drop_count)
`ifdef MATCH_STATS_EN
    , .stat_issued(stat_issued)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic cfg_write(input logic [3:0] idx, input logic [47:0] mac, input logic [1:0] port, input logic en);
    cfg_wr = 1'b1; cfg_idx = idx; cfg_mac = mac; cfg_port = port; cfg_en = en;
    @(posedge clock); #1;
    cfg_wr = 1'b0;
  endtask

  task automatic drive_beat(input int ifc, input logic [47:0] mac, input logic sop, input logic eop, input logic [5:0] ch);
    bit took = 1'b0;
    packetout_data[ifc]    = {mac, 16'($urandom)};
    packetout_sop[ifc]     = sop;
    packetout_eop[ifc]     = eop;
    packetout_channel[ifc] = ch;
    packetout_valid[ifc]   = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (packetout_ready[ifc] === 1'b1) begin took = 1'b1; break; end
    end
    @(posedge clock); #1;
    packetout_valid[ifc] = 1'b0;
    packetout_sop[ifc]   = 1'b0;
    packetout_eop[ifc]   = 1'b0;
    if (!took) drive_ok = 1'b0;
  endtask

  // Waits (bounded) for a result handshake; leaves time just before that edge.
  task automatic wait_handshake(output bit ok, output int cycles);
    ok = 1'b0; cycles = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (tagin_valid === 1'b1 && tagin_ready === 1'b1) begin ok = 1'b1; cycles = c; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock); #1;
    checks++; if (tagin_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", tagin_valid); end
    checks++; if (tagin_data !== 10'd0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 000", tagin_data); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_drop: got %0d expected 0", drop_count); end
    checks++; if (packetout_ready !== 4'hF) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1111", packetout_ready); end
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_match_latency();
    drive_ok = 1'b1;
    tagin_ready = 1'b1;
    cfg_write(4'd3, MAC_A, 2'd2, 1'b1);
    drive_beat(1, MAC_A, 1'b1, 1'b0, 6'd5);
    drive_beat(1, MAC_MISS, 1'b0, 1'b0, 6'd5);
    drive_beat(1, MAC_B, 1'b0, 1'b0, 6'd5);
    sb.push_back(10'b10_01_000101);
    drive_beat(1, MAC_MISS, 1'b0, 1'b1, 6'd5);
    @(negedge clock);
    checks++; if (tagin_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_early: valid got %b expected 0", tagin_valid); end
    @(posedge clock); #1;
    @(negedge clock);
    exp_data = sb.pop_front();
    checks++; if (tagin_valid !== 1'b1) begin errors++; $display("[TB] FAIL latency_valid: got %b expected 1", tagin_valid); end
    checks++; if (tagin_data !== exp_data) begin errors++; $display("[TB] FAIL match_data: got %b expected %b", tagin_data, exp_data); end
    @(posedge clock); #1;
    checks++; if (!drive_ok) begin errors++; $display("[TB] FAIL match_drive: got stalled expected accepted"); end
  endtask

  task automatic test_default_port();
    sb.push_back(10'b00_11_111111);
    drive_beat(3, MAC_MISS, 1'b1, 1'b1, 6'd63);
    wait_handshake(got, waited);
    checks++;
    if (!got) begin errors++; $display("[TB] FAIL default_port: got timeout expected result"); void'(sb.pop_front()); end
    else begin
      exp_data = sb.pop_front();
      if (tagin_data !== exp_data) begin errors++; $display("[TB] FAIL default_port: got %b expected %b", tagin_data, exp_data); end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_round_robin();
    bit consecutive = 1'b1;
    for (int i = 0; i < 4; i++) begin
      packetout_data[i]    = {MAC_A, 16'h0};
      packetout_sop[i]     = 1'b1;
      packetout_eop[i]     = 1'b1;
      packetout_channel[i] = 6'(10 + i);
      packetout_valid[i]   = 1'b1;
      sb.push_back({2'd2, 2'(i), 6'(10 + i)});
    end
    @(posedge clock); #1;
    packetout_valid = '0; packetout_sop = '0; packetout_eop = '0;
    for (int n = 0; n < 4; n++) begin
      wait_handshake(got, waited);
      if (n > 0 && waited != 0) consecutive = 1'b0;
      checks++;
      exp_data = sb.pop_front();
      if (!got || tagin_data !== exp_data) begin errors++; $display("[TB] FAIL rr_order%0d: got %b expected %b", n, tagin_data, exp_data); end
      @(posedge clock); #1;
    end
    checks++; if (!consecutive) begin errors++; $display("[TB] FAIL rr_consecutive: got gaps expected back-to-back"); end
    // Pointer ends at 2 after this single result, so interface 3 wins next.
    sb.push_back(10'b10_01_101000);
    drive_beat(1, MAC_A, 1'b1, 1'b1, 6'd40);
    wait_handshake(got, waited);
    checks++;
    exp_data = sb.pop_front();
    if (!got || tagin_data !== exp_data) begin errors++; $display("[TB] FAIL rr_single: got %b expected %b", tagin_data, exp_data); end
    @(posedge clock); #1;
    packetout_data[0] = {MAC_A, 16'h0}; packetout_channel[0] = 6'd41;
    packetout_data[3] = {MAC_A, 16'h0}; packetout_channel[3] = 6'd42;
    packetout_sop = 4'b1001; packetout_eop = 4'b1001; packetout_valid = 4'b1001;
    sb.push_back({2'd2, 2'd3, 6'd42});
    sb.push_back({2'd2, 2'd0, 6'd41});
    @(posedge clock); #1;
    packetout_valid = '0; packetout_sop = '0; packetout_eop = '0;
    for (int n = 0; n < 2; n++) begin
      wait_handshake(got, waited);
      checks++;
      exp_data = sb.pop_front();
      if (!got || tagin_data !== exp_data) begin errors++; $display("[TB] FAIL rr_pointer%0d: got %b expected %b", n, tagin_data, exp_data); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_back_pressure();
    bit stable = 1'b1;
    drive_ok = 1'b1;
    tagin_ready = 1'b0;
    for (int p = 0; p < 5; p++) begin
      sb.push_back({2'd0, 2'd0, 6'(20 + p)});
      drive_beat(0, MAC_MISS, 1'b1, 1'b1, 6'(20 + p));
    end
    @(negedge clock);
    checks++; if (packetout_ready[0] !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_low: got %b expected 0", packetout_ready[0]); end
    checks++; if (!drive_ok) begin errors++; $display("[TB] FAIL bp_accept: got stalled expected 5 accepted"); end
    for (int c = 0; c < 4; c++) begin
      if (tagin_valid !== 1'b1 || tagin_data !== sb[0]) stable = 1'b0;
      @(negedge clock);
    end
    checks++; if (!stable) begin errors++; $display("[TB] FAIL bp_hold: got %b expected %b held", tagin_data, sb[0]); end
    @(posedge clock); #1;
    tagin_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      wait_handshake(got, waited);
      checks++;
      exp_data = sb.pop_front();
      if (!got || tagin_data !== exp_data) begin errors++; $display("[TB] FAIL bp_drain%0d: got %b expected %b", n, tagin_data, exp_data); end
      @(posedge clock); #1;
    end
    checks++; if (packetout_ready[0] !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_high: got %b expected 1", packetout_ready[0]); end
  endtask

  task automatic test_drops();
    bit extra = 1'b0;
    drive_beat(2, MAC_A, 1'b1, 1'b0, 6'd7);
    drive_beat(2, MAC_B, 1'b0, 1'b0, 6'd7);
    drive_beat(2, MAC_MISS, 1'b1, 1'b0, 6'd9);
    sb.push_back(10'b00_10_001001);
    drive_beat(2, MAC_B, 1'b0, 1'b1, 6'd9);
    wait_handshake(got, waited);
    checks++;
    exp_data = sb.pop_front();
    if (!got || tagin_data !== exp_data) begin errors++; $display("[TB] FAIL drop_result: got %b expected %b", tagin_data, exp_data); end
    @(posedge clock); #1;
    checks++; if (drop_count !== 16'd1) begin errors++; $display("[TB] FAIL drop_resop: got %0d expected 1", drop_count); end
    drive_beat(2, MAC_B, 1'b0, 1'b1, 6'd9);
    @(negedge clock);
    checks++; if (drop_count !== 16'd2) begin errors++; $display("[TB] FAIL drop_orphan: got %0d expected 2", drop_count); end
    for (int c = 0; c < 8; c++) begin
      if (tagin_valid !== 1'b0) extra = 1'b1;
      @(negedge clock);
    end
    checks++; if (extra) begin errors++; $display("[TB] FAIL drop_no_extra: got extra result expected none"); end
    @(posedge clock); #1;
  endtask

  task automatic test_cfg_timing();
    // Table write and lookup share an edge: the lookup must miss.
    cfg_wr = 1'b1; cfg_idx = 4'd0; cfg_mac = MAC_B; cfg_port = 2'd1; cfg_en = 1'b1;
    packetout_data[0] = {MAC_B, 16'h0}; packetout_channel[0] = 6'd50;
    packetout_sop[0] = 1'b1; packetout_eop[0] = 1'b1; packetout_valid[0] = 1'b1;
    sb.push_back(10'b00_00_110010);
    @(posedge clock); #1;
    cfg_wr = 1'b0;
    packetout_valid = '0; packetout_sop = '0; packetout_eop = '0;
    sb.push_back(10'b01_00_110011);
    drive_beat(0, MAC_B, 1'b1, 1'b1, 6'd51);
    for (int n = 0; n < 2; n++) begin
      wait_handshake(got, waited);
      checks++;
      exp_data = sb.pop_front();
      if (!got || tagin_data !== exp_data) begin errors++; $display("[TB] FAIL cfg_timing%0d: got %b expected %b", n, tagin_data, exp_data); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_priority();
    cfg_write(4'd1, MAC_X, 2'd3, 1'b1);
    cfg_write(4'd4, MAC_X, 2'd0, 1'b1);
    sb.push_back(10'b11_00_100001);
    drive_beat(0, MAC_X, 1'b1, 1'b1, 6'd33);
    wait_handshake(got, waited);
    checks++;
    exp_data = sb.pop_front();
    if (!got || tagin_data !== exp_data) begin errors++; $display("[TB] FAIL priority: got %b expected %b", tagin_data, exp_data); end
    @(posedge clock); #1;
`ifdef MATCH_STATS_EN
    checks++; if (stat_issued[3] !== 32'd1) begin errors++; $display("[TB] FAIL stat_port3: got %0d expected 1", stat_issued[3]); end
`endif
  endtask

  task automatic test_async_reset();
    drive_beat(1, MAC_X, 1'b1, 1'b0, 6'd12);
    #3 reset = 1'b0;
    #1;
    checks++; if (drop_count !== 16'd0) begin errors++; $display("[TB] FAIL arst_drop: got %0d expected 0", drop_count); end
    checks++; if (tagin_valid !== 1'b0) begin errors++; $display("[TB] FAIL arst_valid: got %b expected 0", tagin_valid); end
`ifdef MATCH_STATS_EN
    checks++; if (stat_issued !== '0) begin errors++; $display("[TB] FAIL arst_stats: got %h expected 0", stat_issued); end
`endif
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    // An EOP here is an orphan only if the in-packet flag was cleared.
    drive_beat(1, MAC_X, 1'b0, 1'b1, 6'd12);
    @(negedge clock);
    checks++; if (drop_count !== 16'd1) begin errors++; $display("[TB] FAIL arst_state: got %0d expected 1", drop_count); end
    @(posedge clock); #1;
    sb.push_back(10'b00_01_000010);
    drive_beat(1, MAC_X, 1'b1, 1'b1, 6'd2);
    wait_handshake(got, waited);
    checks++;
    exp_data = sb.pop_front();
    if (!got || tagin_data !== exp_data) begin errors++; $display("[TB] FAIL arst_table: got %b expected %b", tagin_data, exp_data); end
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b0;
    packetout_data = '0; packetout_valid = '0; packetout_sop = '0;
    packetout_eop = '0; packetout_channel = '0; tagin_ready = 1'b0;
    cfg_wr = 1'b0; cfg_idx = '0; cfg_mac = '0; cfg_port = '0; cfg_en = 1'b0;
    $display("[TB] starting match_dispatch bench");
    test_reset();
    test_match_latency();
    test_default_port();
    test_round_robin();
    test_back_pressure();
    test_drops();
    test_cfg_timing();
    test_priority();
    test_async_reset();
    checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_left: got %0d expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
